// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the three-way RAM arbiter (VGA / CPU / DMA).
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ARB_LATENCY = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority select: VGA first, then CPU before DMA unless DMA is starving.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   vga_cand,
  input  logic   cpu_cand,
  input  logic   dma_cand,
  input  logic   starve,
  output owner_e grant_c
);

  always_comb begin
    grant_c = OWN_NONE;
    if (vga_cand) begin
      grant_c = OWN_VGA;
    end else if (starve && dma_cand) begin
      grant_c = OWN_DMA;
    end else if (cpu_cand) begin
      grant_c = OWN_CPU;
    end else if (dma_cand) begin
      grant_c = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous 64Kx8 RAM between VGA fetch, CPU and DMA with a
// 3-stage owner-tagged pipeline; response pulses arrive 3 cycles after grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DMA_STARVE = 8
)
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_ce,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_a,
  output logic [DATA_W-1:0] vga_q,
  output logic              vga_valid,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_d,
  input  logic              dma_we,
  output logic [DATA_W-1:0] dma_q,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W      = $clog2(DMA_STARVE + 1);
  localparam int unsigned RESP_STAGE = ARB_LATENCY - 2;

  owner_e           tag [ARB_LATENCY];
  owner_e           grant_c;
  logic             cpu_cand_c;
  logic             dma_busy_c;
  logic             dma_cand_c;
  logic             starve_c;
  logic [CNT_W-1:0] starve_cnt;
  logic             we_s2;
  mem_req_t         req_c;

  // A requester with a tag anywhere in the pipeline already has its one access in flight.
  always_comb begin
    cpu_cand_c = 1'b1;
    dma_busy_c = 1'b0;
    for (int i = 0; i < ARB_LATENCY; i++) begin
      if (tag[i] == OWN_CPU) cpu_cand_c = 1'b0;
      if (tag[i] == OWN_DMA) dma_busy_c = 1'b1;
    end
    dma_cand_c = dma_req && !dma_busy_c;
    starve_c   = (starve_cnt >= CNT_W'(DMA_STARVE));
  end

  mem_arb_pick u_pick (
    .vga_cand (vga_req),
    .cpu_cand (cpu_cand_c),
    .dma_cand (dma_cand_c),
    .starve   (starve_c),
    .grant_c  (grant_c)
  );

  always_comb begin
    req_c = '0;
    case (grant_c)
      OWN_VGA: req_c.a = vga_a;
      OWN_CPU: begin
        req_c.a  = cpu_a;
        req_c.d  = cpu_d;
        req_c.we = cpu_we;
      end
      OWN_DMA: begin
        req_c.a  = dma_a;
        req_c.d  = dma_d;
        req_c.we = dma_we;
      end
      default: ;
    endcase
  end

  // Counts slots DMA was eligible but lost; saturates at the starve threshold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!dma_req || grant_c == OWN_DMA) begin
      starve_cnt <= '0;
    end else if (dma_cand_c && !starve_c) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARB_LATENCY; i++) tag[i] <= OWN_NONE;
      ram_a     <= '0;
      ram_d     <= '0;
      ram_we    <= 1'b0;
      we_s2     <= 1'b0;
      cpu_q     <= '0;
      vga_q     <= '0;
      dma_q     <= '0;
      cpu_ce    <= 1'b0;
      vga_valid <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      tag[0] <= grant_c;
      for (int i = 1; i < ARB_LATENCY; i++) tag[i] <= tag[i-1];

      ram_we <= (grant_c != OWN_NONE) && req_c.we;
      if (grant_c != OWN_NONE) begin
        ram_a <= req_c.a;
        ram_d <= req_c.d;
      end
      we_s2 <= ram_we;

      // RAM data is valid in the stage after the address; route it to the owner.
      vga_valid <= (tag[RESP_STAGE] == OWN_VGA);
      cpu_ce    <= (tag[RESP_STAGE] == OWN_CPU);
      dma_ack   <= (tag[RESP_STAGE] == OWN_DMA);
      if (tag[RESP_STAGE] == OWN_VGA) vga_q <= ram_q;
      if (tag[RESP_STAGE] == OWN_CPU && !we_s2) cpu_q <= ram_q;
      if (tag[RESP_STAGE] == OWN_DMA && !we_s2) dma_q <= ram_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM environment, transaction-level model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned STARVE = 8;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_a   = 16'h1234;
  logic [7:0]  cpu_d   = 8'h00;
  logic        cpu_we  = 1'b0;
  logic        vga_req = 1'b0;
  logic [15:0] vga_a   = 16'h0000;
  logic        dma_req = 1'b0;
  logic [15:0] dma_a   = 16'h0000;
  logic [7:0]  dma_d   = 8'h00;
  logic        dma_we  = 1'b0;
  logic [7:0]  cpu_q, vga_q, dma_q, ram_d, ram_q;
  logic        cpu_ce, vga_valid, dma_ack, ram_we;
  logic [15:0] ram_a;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DMA_STARVE(STARVE)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_q(cpu_q), .cpu_ce(cpu_ce),
    .vga_req(vga_req), .vga_a(vga_a), .vga_q(vga_q), .vga_valid(vga_valid),
    .dma_req(dma_req), .dma_a(dma_a), .dma_d(dma_d), .dma_we(dma_we),
    .dma_q(dma_q), .dma_ack(dma_ack),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial forever #5 clock = ~clock;

  // Synchronous RAM: data appears the cycle after the address.
  logic [7:0] ram_mem [65536];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_a] <= ram_d;
    ram_q <= ram_mem[ram_a];
  end

  // Transaction-level model
  typedef struct packed {
    owner_e     own;
    logic       we;
    logic [7:0] data;
  } resp_t;

  logic [7:0]  mdl_mem [65536];
  resp_t       resp [3];
  int          cpu_wait, dma_wait, starve;
  logic [15:0] e_ram_a;
  logic [7:0]  e_ram_d, e_cpu_q, e_vga_q, e_dma_q;
  logic        e_ram_we;

  task automatic mdl_clear();
    for (int i = 0; i < 3; i++) resp[i] = '{own: OWN_NONE, we: 1'b0, data: 8'h00};
    cpu_wait = 0; dma_wait = 0; starve = 0;
    e_ram_a = 16'h0000; e_ram_d = 8'h00; e_ram_we = 1'b0;
    e_cpu_q = 8'h00; e_vga_q = 8'h00; e_dma_q = 8'h00;
  endtask

  task automatic mdl_step();
    owner_e      win;
    logic        cpu_ok, dma_ok, w;
    logic [15:0] a;
    logic [7:0]  d;
    resp_t       nr;
    cpu_ok = (cpu_wait == 0);
    dma_ok = dma_req && (dma_wait == 0);
    if (vga_req)                                   win = OWN_VGA;
    else if (dma_ok && (starve >= STARVE || !cpu_ok)) win = OWN_DMA;
    else if (cpu_ok)                               win = OWN_CPU;
    else                                           win = OWN_NONE;
    if (!dma_req || win == OWN_DMA) starve = 0;
    else if (dma_ok) starve = (starve + 1 > STARVE) ? STARVE : starve + 1;
    cpu_wait = (win == OWN_CPU) ? ARB_LATENCY : ((cpu_wait > 0) ? cpu_wait - 1 : 0);
    dma_wait = (win == OWN_DMA) ? ARB_LATENCY : ((dma_wait > 0) ? dma_wait - 1 : 0);
    a = e_ram_a; d = 8'h00; w = 1'b0;
    case (win)
      OWN_VGA: a = vga_a;
      OWN_CPU: begin a = cpu_a; d = cpu_d; w = cpu_we; end
      OWN_DMA: begin a = dma_a; d = dma_d; w = dma_we; end
      default: ;
    endcase
    e_ram_we = (win != OWN_NONE) && w;
    if (win != OWN_NONE) begin
      e_ram_a = a;
      if (w) e_ram_d = d;
    end
    nr.own = win; nr.we = w; nr.data = mdl_mem[a];
    if (win != OWN_NONE && w) mdl_mem[a] = d;
    resp[2] = resp[1]; resp[1] = resp[0]; resp[0] = nr;
    if (resp[2].own == OWN_VGA) e_vga_q = resp[2].data;
    if (resp[2].own == OWN_CPU && !resp[2].we) e_cpu_q = resp[2].data;
    if (resp[2].own == OWN_DMA && !resp[2].we) e_dma_q = resp[2].data;
  endtask

  initial begin
    mdl_clear();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) mdl_clear();
      else mdl_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      chk("ram_we", 32'(ram_we), 32'(e_ram_we));
      chk("ram_a", 32'(ram_a), 32'(e_ram_a));
      if (e_ram_we) chk("ram_d", 32'(ram_d), 32'(e_ram_d));
      chk("cpu_ce", 32'(cpu_ce), 32'(resp[2].own == OWN_CPU));
      chk("vga_valid", 32'(vga_valid), 32'(resp[2].own == OWN_VGA));
      chk("dma_ack", 32'(dma_ack), 32'(resp[2].own == OWN_DMA));
      chk("cpu_q", 32'(cpu_q), 32'(e_cpu_q));
      chk("vga_q", 32'(vga_q), 32'(e_vga_q));
      chk("dma_q", 32'(dma_q), 32'(e_dma_q));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic nedge(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_cpu_ce(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      ok = cpu_ce;
    end
  endtask

  task automatic wait_dma_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      ok = dma_ack;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bit got;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'(i * 37 + 11);
      mdl_mem[i] = 8'(i * 37 + 11);
    end
    ram_mem[16'h1234] = 8'h5A; mdl_mem[16'h1234] = 8'h5A;
    ram_mem[16'h4000] = 8'hC3; mdl_mem[16'h4000] = 8'hC3;
    ram_mem[16'h8000] = 8'h00; mdl_mem[16'h8000] = 8'h00;
    ram_mem[16'h9000] = 8'h3C; mdl_mem[16'h9000] = 8'h3C;
    ram_mem[16'h0100] = 8'h11; mdl_mem[16'h0100] = 8'h11;
    ram_mem[16'h0010] = 8'h00; mdl_mem[16'h0010] = 8'h00;

    // Reset state
    repeat (3) step();
    @(negedge clock);
    chk("rst cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_a", 32'(ram_a), 32'd0);
    chk("rst cpu_q", 32'(cpu_q), 32'd0);
    chk("rst vga_valid", 32'(vga_valid), 32'd0);
    chk("rst dma_ack", 32'(dma_ack), 32'd0);

    // CPU alone reads 0x1234, then repeats every 4 cycles
    step(); reset_n = 1'b1;
    nedge(2);
    chk("A ram_a t+1", 32'(ram_a), 32'h1234);
    nedge(2);
    chk("A cpu_ce t+3", 32'(cpu_ce), 32'd1);
    chk("A cpu_q", 32'(cpu_q), 32'h5A);
    nedge(4);
    chk("A cpu_ce t+7", 32'(cpu_ce), 32'd1);

    // VGA and CPU in the same cycle: VGA first
    step(); vga_req = 1'b1; vga_a = 16'h4000;
    step(); vga_req = 1'b0;
    @(negedge clock);
    chk("B ram_a vga", 32'(ram_a), 32'h4000);
    @(negedge clock);
    chk("B ram_a cpu", 32'(ram_a), 32'h1234);
    @(negedge clock);
    chk("B vga_valid", 32'(vga_valid), 32'd1);
    chk("B vga_q", 32'(vga_q), 32'hC3);
    chk("B cpu_ce early", 32'(cpu_ce), 32'd0);
    @(negedge clock);
    chk("B cpu_ce t+4", 32'(cpu_ce), 32'd1);

    // CPU write 0xFF to 0x0010, then read it back
    cpu_a = 16'h0010; cpu_d = 8'hFF; cpu_we = 1'b1;
    nedge(2);
    chk("C ram_we", 32'(ram_we), 32'd1);
    chk("C ram_a", 32'(ram_a), 32'h0010);
    chk("C ram_d", 32'(ram_d), 32'hFF);
    nedge(1);
    chk("C ram_we one cycle", 32'(ram_we), 32'd0);
    nedge(1);
    chk("C cpu_ce", 32'(cpu_ce), 32'd1);
    chk("C cpu_q kept", 32'(cpu_q), 32'h5A);
    cpu_we = 1'b0;
    nedge(4);
    chk("C readback ce", 32'(cpu_ce), 32'd1);
    chk("C readback q", 32'(cpu_q), 32'hFF);

    // DMA write 0x77 to 0x8000 while the CPU keeps its slots
    cpu_a = 16'h8000;
    step(); dma_req = 1'b1; dma_a = 16'h8000; dma_d = 8'h77; dma_we = 1'b1;
    wait_cpu_ce(8, ok);
    chk("D cpu served first", 32'(ok), 32'd1);
    chk("D dma_ack not yet", 32'(dma_ack), 32'd0);
    wait_dma_ack(8, ok);
    chk("D dma_ack seen", 32'(ok), 32'd1);
    step(); dma_req = 1'b0; dma_we = 1'b0;
    wait_cpu_ce(8, ok);
    chk("D cpu readback ce", 32'(ok), 32'd1);
    chk("D cpu readback q", 32'(cpu_q), 32'h77);

    // Saturated starve counter lets DMA beat the CPU
    cpu_a = 16'h0100;
    step(); dma_req = 1'b1; dma_a = 16'h9000;
    for (int k = 0; k < 10; k++) begin
      vga_req = 1'b1; vga_a = 16'h4000 + 16'(k);
      step();
    end
    vga_req = 1'b0;
    nedge(2);
    chk("E dma wins", 32'(ram_a), 32'h9000);
    nedge(1);
    chk("E cpu next", 32'(ram_a), 32'h0100);
    nedge(1);
    chk("E dma_ack", 32'(dma_ack), 32'd1);
    chk("E dma_q", 32'(dma_q), 32'h3C);
    step(); dma_req = 1'b0;

    // VGA every other cycle, CPU continuous, DMA held
    dma_a = 16'h9001; dma_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vga_req = (k % 2 == 0); vga_a = 16'h5000 + 16'(k);
      @(negedge clock);
      if (dma_ack) begin
        got = 1'b1;
        dma_req = 1'b0;
      end
      step();
    end
    vga_req = 1'b0; dma_req = 1'b0;
    chk("F dma served", 32'(got), 32'd1);

    // Reset one cycle into a CPU read: no completion, clean restart
    cpu_a = 16'h1234;
    wait_cpu_ce(8, ok);
    chk("G sync ce", 32'(ok), 32'd1);
    step();
    step(); reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("G no cpu_ce", 32'(cpu_ce), 32'd0);
      chk("G ram_we 0", 32'(ram_we), 32'd0);
      chk("G ram_a 0", 32'(ram_a), 32'd0);
      chk("G cpu_q 0", 32'(cpu_q), 32'd0);
    end
    step(); reset_n = 1'b1;
    wait_cpu_ce(6, ok);
    chk("G post-reset ce", 32'(ok), 32'd1);
    chk("G post-reset q", 32'(cpu_q), 32'h5A);

    nedge(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-way arbiter sharing one single-port synchronous 64K×8 RAM between the VGA fetch unit, the LCR580 CPU and a DMA master (SD card loader). It sits between the requesters and the RAM block, in the same clock domain. The CPU is throttled through its `ce` input; VGA reads are pipelined; DMA uses a req/ack handshake with starvation protection.

## Interface
- `DMA_STARVE`, 8: lost arbitration slots after which DMA outranks the CPU.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_a`  in  16  CPU address, stable while `cpu_ce`=0.
- `cpu_d`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write strobe (1=write).
- `cpu_q`  out  8  CPU read data, valid when `cpu_ce`=1.
- `cpu_ce`  out  1  CPU clock enable; 1-cycle pulse per completed access.
- `vga_req`  in  1  VGA read request, 1 cycle per read.
- `vga_a`  in  16  VGA read address, sampled with `vga_req`.
- `vga_q`  out  8  VGA read data.
- `vga_valid`  out  1  1-cycle pulse, `vga_q` valid.
- `dma_req`  in  1  DMA request; held high until `dma_ack`.
- `dma_a`  in  16  DMA address, held with `dma_req`.
- `dma_d`  in  8  DMA write data.
- `dma_we`  in  1  DMA write (1) / read (0).
- `dma_q`  out  8  DMA read data, valid with `dma_ack`.
- `dma_ack`  out  1  1-cycle completion pulse.
- `ram_a`  out  16  RAM address.
- `ram_d`  out  8  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_q`  in  8  RAM read data, valid the cycle after `ram_a` is presented.

## Operation
- One grant per cycle. Candidates: VGA if `vga_req`; CPU if no CPU access in flight (CPU request is implicit and always present); DMA if `dma_req` and no DMA access in flight.
- Priority: VGA > CPU > DMA. When DMA starve counter ≥ `DMA_STARVE`: VGA > DMA > CPU.
- Starve counter: +1 (saturating at `DMA_STARVE`) each cycle DMA is a candidate but not granted; cleared on DMA grant or when `dma_req`=0.
- Owner tag (NONE/VGA/CPU/DMA) travels through a 3-stage pipeline with the access.
- CPU and DMA: at most one access in flight each; VGA: one new read per cycle allowed. System requirement: VGA source issues at most one `vga_req` per 2 cycles, bounding CPU wait to one slot.
- Writes: `ram_we` high exactly one cycle; completion pulse (`cpu_ce` / `dma_ack`) at the same latency as reads; `cpu_q`/`dma_q` retain the previous value on writes.
- Idle cycles: `ram_we`=0, `ram_a` holds last value.

## Timing
- Cycle t: arbitration; winner's address/data/we registered at end of t.
- t+1: `ram_a`/`ram_d`/`ram_we` driven; RAM access.
- t+2: `ram_q` valid; captured into owner's `*_q` at end of t+2.
- t+3: owner's `vga_valid` / `cpu_ce` / `dma_ack` high for one cycle. Request-to-response latency: 3 cycles.
- CPU next access arbitrated at t+4 at the earliest (CPU advances on the `cpu_ce` edge). DMA may drop `dma_req` in t+4; a still-high `dma_req` in t+4 is a new request.
- Reset: all outputs 0 (`cpu_ce`=0, `ram_we`=0, `*_valid`/`ack`=0, data 0), starve counter 0, pipeline tags NONE. Reset mid-operation discards in-flight accesses: no completion pulse, no write issued after reset asserts.
- Simultaneous VGA+CPU+DMA in t: VGA granted; CPU in t+1; DMA in t+2 if no new VGA/CPU candidate, else per starve rule.

## Structure
- Package `mem_arb_pkg`: owner enum (2 bits: OWN_NONE, OWN_VGA, OWN_CPU, OWN_DMA), `ARB_LATENCY`=3, address/data widths 16/8.
- Sub-module `mem_arb_pick`: combinational priority select (candidates + starve flag → owner). Pipeline, starve counter and response routing stay in `mem_arbiter`.

## Test plan
- Reset, CPU alone reads 0x1234 containing 0x5A: `ram_a`=0x1234 at t+1, `cpu_ce` pulse with `cpu_q`=0x5A at t+3, repeat every 4 cycles.
- VGA `vga_req` at 0x4000 and CPU pending in same cycle: VGA granted (valid at t+3), CPU `ram_a` at t+2, `cpu_ce` at t+4.
- DMA write 0x77 to 0x8000 while CPU busy: `dma_ack` only after CPU slot; readback by CPU returns 0x77.
- VGA every 2 cycles + continuous CPU + DMA held: DMA granted no later than `DMA_STARVE`=8 lost slots after request.
- CPU write 0xFF to 0x0010: `ram_we` high exactly one cycle with `ram_d`=0xFF, `cpu_ce` at t+3, `cpu_q` unchanged.
- Assert `reset_n`=0 at t+1 of CPU read: no `cpu_ce` pulse, all outputs 0; first post-reset access completes normally.
